// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic result drain:
//   - default array geometry
//   - acc_width(): element width derived from the operand width (3 * DATA_WIDTH)
//   - drain_state_e: drain FSM state encoding (IDLE / STREAM / DONE)
//   - elem_offset(): bit offset of element (row, col) inside the flat result bus
// No ports (package).
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int DEFAULT_SIZE       = 4;
   localparam int DEFAULT_DATA_WIDTH = 8;

   // Accumulator width: a product needs 2*DATA_WIDTH, the remainder is
   // headroom for summing partial products along the array.
   function automatic int acc_width(input int data_width);
      return 3 * data_width;
   endfunction

   typedef enum logic [1:0] {
      DRAIN_IDLE   = 2'd0,
      DRAIN_STREAM = 2'd1,
      DRAIN_DONE   = 2'd2
   } drain_state_e;

   // Element (row, col) occupies bits [offset +: acc_w] of the flat matrix.
   function automatic int elem_offset(input int row, input int col,
                                      input int size, input int acc_w);
      return (row * size + col) * acc_w;
   endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// -----------------------------------------------------------------------------
// systolic_result_drain_if
// Bundles the array-result side, the element stream and the status flags of
// the result drain.
//   master : array/write-back side (drives result_*, matrix_size, out_ready)
//   slave  : the drain itself (drives out_*, busy, drain_done, overrun)
// Signals:
//   result_valid   array result flag (level)
//   result_matrix  flat SIZE*SIZE*ACC_WIDTH result bus
//   matrix_size    active size, sampled at capture
//   out_valid/out_ready  element stream handshake
//   out_data/out_row/out_col/out_last/out_sat  element beat payload
//   busy, drain_done, overrun  status
// -----------------------------------------------------------------------------
interface systolic_result_drain_if #(
   parameter int SIZE       = 4,
   parameter int DATA_WIDTH = 8
);
   import systolic_pkg::*;

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH);
   localparam int RC_WIDTH  = $clog2(SIZE);
   localparam int N_WIDTH   = $clog2(SIZE + 1);

   logic                              result_valid;
   logic [SIZE*SIZE*ACC_WIDTH-1:0]    result_matrix;
   logic [N_WIDTH-1:0]                matrix_size;

   logic                              out_valid;
   logic                              out_ready;
   logic signed [ACC_WIDTH-1:0]       out_data;
   logic [RC_WIDTH-1:0]               out_row;
   logic [RC_WIDTH-1:0]               out_col;
   logic                              out_last;
   logic                              out_sat;

   logic                              busy;
   logic                              drain_done;
   logic                              overrun;

   modport master (
      output result_valid, result_matrix, matrix_size, out_ready,
      input  out_valid, out_data, out_row, out_col, out_last, out_sat,
             busy, drain_done, overrun
   );

   modport slave (
      input  result_valid, result_matrix, matrix_size, out_ready,
      output out_valid, out_data, out_row, out_col, out_last, out_sat,
             busy, drain_done, overrun
   );

endinterface

// File: rtl/systolic_sat_clamp.sv
// -----------------------------------------------------------------------------
// systolic_sat_clamp
// Combinational clamp of a signed IN_WIDTH value to the signed OUT_WIDTH range,
// result sign-extended back to IN_WIDTH. Only compiled when
// RESULT_DRAIN_SAT_EN is defined (the only build that instantiates it).
// Ports:
//   data_i  in   IN_WIDTH  signed element
//   data_o  out  IN_WIDTH  clamped element, sign-extended
//   sat_o   out  1         high when data_i was outside the OUT_WIDTH range
// -----------------------------------------------------------------------------
`ifdef RESULT_DRAIN_SAT_EN
module systolic_sat_clamp #(
   parameter int IN_WIDTH  = 24,
   parameter int OUT_WIDTH = 16
) (
   input  logic [IN_WIDTH-1:0] data_i,
   output logic [IN_WIDTH-1:0] data_o,
   output logic                sat_o
);

   // Limits already sign-extended to IN_WIDTH so the compare is a plain
   // signed compare at full width.
   localparam logic signed [IN_WIDTH-1:0] MAX_V =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [IN_WIDTH-1:0] MIN_V =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic signed [IN_WIDTH-1:0] data_s;

   assign data_s = $signed(data_i);

   always_comb begin
      // NOTE: both outputs get a default before any branch, so no path can
      // leave them unassigned and infer a latch.
      data_o = data_i;
      sat_o  = 1'b0;
      if (data_s > MAX_V) begin
         data_o = MAX_V;
         sat_o  = 1'b1;
      end else if (data_s < MIN_V) begin
         data_o = MIN_V;
         sat_o  = 1'b1;
      end
   end

endmodule
`endif

// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
// Consumer end of the systolic array result interface. A rising edge on
// result_valid captures the flat result matrix and the active size n, then the
// n x n active elements are streamed row-major, one per valid/ready beat.
// Optional feature: RESULT_DRAIN_SAT_EN -- clamp each element to the signed
// 2*DATA_WIDTH range (flagged on out_sat); otherwise raw data, out_sat = 0.
// Ports:
//   clk   in  clock, all logic on posedge
//   rst   in  synchronous active-high reset
//   bus   systolic_result_drain_if.slave:
//         result_valid/result_matrix/matrix_size in, out_ready in,
//         out_valid/out_data/out_row/out_col/out_last/out_sat out,
//         busy/drain_done/overrun out
// -----------------------------------------------------------------------------
module systolic_result_drain
   import systolic_pkg::*;
#(
   parameter int SIZE       = DEFAULT_SIZE,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   systolic_result_drain_if.slave bus
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH);
   localparam int RC_WIDTH  = $clog2(SIZE);
   localparam int N_WIDTH   = $clog2(SIZE + 1);
   localparam int MAT_WIDTH = SIZE * SIZE * ACC_WIDTH;
   localparam logic [N_WIDTH-1:0] SIZE_N = N_WIDTH'(SIZE);

   drain_state_e           state_q,  state_d;
   logic                   result_valid_q;
   logic [MAT_WIDTH-1:0]   matrix_q, matrix_d;
   logic [N_WIDTH-1:0]     n_q,      n_d;
   logic [RC_WIDTH-1:0]    row_q,    row_d;
   logic [RC_WIDTH-1:0]    col_q,    col_d;
   logic                   overrun_q, overrun_d;

   logic                   trigger;
   logic                   beat_fire;
   logic                   col_end;
   logic                   row_end;
   logic [ACC_WIDTH-1:0]   elems [SIZE][SIZE];
   logic [ACC_WIDTH-1:0]   elem_sel;

   // Rising edge only; a level held high is not a new result. The edge flop
   // is cleared by reset, so a level already high at reset release triggers.
   assign trigger   = bus.result_valid & ~result_valid_q;
   assign beat_fire = (state_q == DRAIN_STREAM) & bus.out_ready;
   assign col_end   = (N_WIDTH'(col_q) == n_q - N_WIDTH'(1));
   assign row_end   = (N_WIDTH'(row_q) == n_q - N_WIDTH'(1));

   // Element mux: view the captured flat bus as a 2-D array, pick (row, col).
   for (genvar r = 0; r < SIZE; r++) begin : g_row
      for (genvar c = 0; c < SIZE; c++) begin : g_col
         assign elems[r][c] = matrix_q[elem_offset(r, c, SIZE, ACC_WIDTH) +: ACC_WIDTH];
      end
   end

   assign elem_sel = elems[row_q][col_q];

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      matrix_d  = matrix_q;
      n_d       = n_q;
      row_d     = row_q;
      col_d     = col_q;
      // A result arriving while a matrix is held is dropped and flagged.
      overrun_d = overrun_q | (trigger & (state_q != DRAIN_IDLE));

      unique case (state_q)
         DRAIN_IDLE: begin
            if (trigger) begin
               if (bus.matrix_size == '0) begin
                  state_d = DRAIN_DONE;
               end else begin
                  state_d  = DRAIN_STREAM;
                  matrix_d = bus.result_matrix;
                  n_d      = (bus.matrix_size > SIZE_N) ? SIZE_N : bus.matrix_size;
                  row_d    = '0;
                  col_d    = '0;
               end
            end
         end

         DRAIN_STREAM: begin
            if (beat_fire) begin
               if (col_end) begin
                  col_d = '0;
                  if (row_end) begin
                     state_d = DRAIN_DONE;
                  end else begin
                     row_d = row_q + RC_WIDTH'(1);
                  end
               end else begin
                  col_d = col_q + RC_WIDTH'(1);
               end
            end
         end

         DRAIN_DONE: begin
            state_d = DRAIN_IDLE;
         end

         default: begin
            state_d = DRAIN_IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the capture register is cleared on reset as well, so it maps
         // to ordinary flops rather than a RAM; outputs read 0 after reset.
         state_q        <= DRAIN_IDLE;
         result_valid_q <= 1'b0;
         matrix_q       <= '0;
         n_q            <= '0;
         row_q          <= '0;
         col_q          <= '0;
         overrun_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q        <= state_d;
         result_valid_q <= bus.result_valid;
         matrix_q       <= matrix_d;
         n_q            <= n_d;
         row_q          <= row_d;
         col_q          <= col_d;
         overrun_q      <= overrun_d;
      end
   end

   // Outputs
   assign bus.out_valid  = (state_q == DRAIN_STREAM);
   assign bus.out_row    = row_q;
   assign bus.out_col    = col_q;
   assign bus.out_last   = (state_q == DRAIN_STREAM) & col_end & row_end;
   assign bus.busy       = (state_q != DRAIN_IDLE);
   assign bus.drain_done = (state_q == DRAIN_DONE);
   assign bus.overrun    = overrun_q;

`ifdef RESULT_DRAIN_SAT_EN
   logic [ACC_WIDTH-1:0] sat_data;
   logic                 sat_flag;

   systolic_sat_clamp #(
      .IN_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH (2 * DATA_WIDTH)
   ) u_sat_clamp (
      .data_i (elem_sel),
      .data_o (sat_data),
      .sat_o  (sat_flag)
   );

   assign bus.out_data = sat_data;
   assign bus.out_sat  = sat_flag;
`else
   assign bus.out_data = elem_sel;
   assign bus.out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// -----------------------------------------------------------------------------
// tb_systolic_result_drain
// Directed bench for systolic_result_drain. Stimulus pushes expected beats into
// a scoreboard queue; a monitor on the falling edge pops and compares every
// accepted beat and checks payload stability while stalled.
// Expectations follow RESULT_DRAIN_SAT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_systolic_result_drain;
   import systolic_pkg::*;

   localparam int SIZE = 4;
   localparam int DW   = 8;
   localparam int ACC  = 24;
   localparam int MATW = SIZE * SIZE * ACC;

   typedef struct packed {
      logic [ACC-1:0] data;
      logic [1:0]     row;
      logic [1:0]     col;
      logic           last;
      logic           sat;
   } beat_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   systolic_result_drain_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) bus ();

   systolic_result_drain #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t sb [$];
   int    checks     = 0;
   int    errors     = 0;
   int    done_cnt   = 0;
   int    beats_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: falling-edge sampling, away from the active edge.
   initial begin : monitor
      beat_t cur;
      beat_t held;
      beat_t exp_b;
      bit    hold_v;
      hold_v = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.drain_done === 1'b1) done_cnt++;
         if (bus.out_valid === 1'b1) begin
            cur = {bus.out_data, bus.out_row, bus.out_col, bus.out_last, bus.out_sat};
            if (hold_v) check("stall_stable", cur, held);
            if (bus.out_ready === 1'b1) begin
               hold_v = 1'b0;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data 0x%0h row %0d col %0d, expected no beat",
                           cur.data, cur.row, cur.col);
               end else begin
                  exp_b = sb.pop_front();
                  check("beat", cur, exp_b);
                  beats_seen++;
               end
            end else begin
               held   = cur;
               hold_v = 1'b1;
            end
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [MATW-1:0] ramp_matrix();
      logic [MATW-1:0] m;
      m = '0;
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            m[(r*SIZE+c)*ACC +: ACC] = ACC'(r * SIZE + c);
      return m;
   endfunction

   task automatic push_beat(input logic [ACC-1:0] d, input int r, input int c,
                            input bit last, input bit sat);
      beat_t b;
      b = {d, 2'(r), 2'(c), last, sat};
      sb.push_back(b);
   endtask

   // Expected beats for the ramp matrix element(r,c) = r*4+c, n x n active.
   task automatic enqueue_ramp(input int n);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            push_beat(ACC'(r * SIZE + c), r, c, (r == n-1) && (c == n-1), 1'b0);
   endtask

   task automatic pulse_rv();
      bus.result_valid = 1'b1;
      tick();
      bus.result_valid = 1'b0;
   endtask

   // Waits for done_cnt to reach target; optionally drives ready 1,0,0,1.
   task automatic wait_done(input int target, input int budget, input string name,
                            input bit bp, output int used);
      used = budget;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt >= target) begin
            used = i;
            break;
         end
         if (bp) bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
         tick();
      end
      bus.out_ready = 1'b1;
      check(name, done_cnt, target);
   endtask

   initial begin : stimulus
      int used;
      int prev;
      int base;
      logic [MATW-1:0] m;

      rst               = 1'b1;
      bus.result_valid  = 1'b0;
      bus.result_matrix = '0;
      bus.matrix_size   = '0;
      bus.out_ready     = 1'b1;
      repeat (3) tick();

      // Reset state
      @(negedge clk);
      check("rst_out_valid",  bus.out_valid,  0);
      check("rst_busy",       bus.busy,       0);
      check("rst_drain_done", bus.drain_done, 0);
      check("rst_overrun",    bus.overrun,    0);
      check("rst_out_last",   bus.out_last,   0);
      check("rst_out_sat",    bus.out_sat,    0);
      check("rst_out_data",   bus.out_data,   0);
      tick();
      rst = 1'b0;
      tick();

      // 1: full 4x4, back-to-back
      bus.result_matrix = ramp_matrix();
      bus.matrix_size   = 3'd4;
      enqueue_ramp(4);
      pulse_rv();
      wait_done(1, 40, "t1_done", 1'b0, used);
      check("t1_throughput_cycles", used, 17);
      repeat (3) tick();
      check("t1_done_once", done_cnt, 1);
      check("t1_sb_empty", sb.size(), 0);
      check("t1_no_overrun", bus.overrun, 0);

      // 2: n=2 sub-matrix
      bus.matrix_size = 3'd2;
      enqueue_ramp(2);
      pulse_rv();
      wait_done(2, 20, "t2_done", 1'b0, used);
      tick();
      check("t2_sb_empty", sb.size(), 0);

      // 3: backpressure 1,0,0,1
      bus.matrix_size = 3'd4;
      enqueue_ramp(4);
      pulse_rv();
      wait_done(3, 120, "t3_done", 1'b1, used);
      tick();
      check("t3_sb_empty", sb.size(), 0);

      // 4: matrix_size=0, result_valid held high 20 cycles
      bus.matrix_size  = 3'd0;
      prev             = done_cnt;
      bus.result_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 3) check("t4_done_latency", done_cnt, prev + 1);
      end
      check("t4_single_capture", done_cnt, prev + 1);
      check("t4_no_overrun", bus.overrun, 0);
      check("t4_busy_idle", bus.busy, 0);
      bus.result_valid = 1'b0;
      tick();

      // Clamp boundaries (raw values in the default build)
      m = '0;
      m[0*ACC +: ACC] = 24'h009C40;   //  40000
      m[1*ACC +: ACC] = 24'hFF63C0;   // -40000
      m[4*ACC +: ACC] = 24'h007FFF;   //  32767
      m[5*ACC +: ACC] = 24'hFF8000;   // -32768
      bus.result_matrix = m;
      bus.matrix_size   = 3'd2;
`ifdef RESULT_DRAIN_SAT_EN
      push_beat(24'h007FFF, 0, 0, 1'b0, 1'b1);
      push_beat(24'hFF8000, 0, 1, 1'b0, 1'b1);
      push_beat(24'h007FFF, 1, 0, 1'b0, 1'b0);
      push_beat(24'hFF8000, 1, 1, 1'b1, 1'b0);
`else
      push_beat(24'h009C40, 0, 0, 1'b0, 1'b0);
      push_beat(24'hFF63C0, 0, 1, 1'b0, 1'b0);
      push_beat(24'h007FFF, 1, 0, 1'b0, 1'b0);
      push_beat(24'hFF8000, 1, 1, 1'b1, 1'b0);
`endif
      pulse_rv();
      wait_done(done_cnt + 1, 20, "sat_done", 1'b0, used);
      tick();
      check("sat_sb_empty", sb.size(), 0);

      // 5: retrigger mid-stream -> overrun, original data continues
      bus.result_matrix = ramp_matrix();
      bus.matrix_size   = 3'd4;
      prev              = done_cnt;
      enqueue_ramp(4);
      pulse_rv();
      repeat (4) tick();
      bus.result_matrix = '1;
      bus.matrix_size   = 3'd1;
      pulse_rv();
      @(negedge clk);
      check("t5_overrun", bus.overrun, 1);
      check("t5_busy", bus.busy, 1);
      tick();
      wait_done(prev + 1, 40, "t5_done", 1'b0, used);
      repeat (3) tick();
      check("t5_done_once", done_cnt, prev + 1);
      check("t5_sb_empty", sb.size(), 0);
      check("t5_overrun_sticky", bus.overrun, 1);

      // 6: reset at beat 5 of 16
      bus.result_matrix = ramp_matrix();
      bus.matrix_size   = 3'd4;
      enqueue_ramp(4);
      base = beats_seen;
      pulse_rv();
      used = 0;
      while ((beats_seen - base) < 5 && used < 40) begin
         tick();
         used++;
      end
      check("t6_reached_beat5", (beats_seen - base) >= 5, 1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("t6_out_valid", bus.out_valid, 0);
      check("t6_busy", bus.busy, 0);
      check("t6_drain_done", bus.drain_done, 0);
      check("t6_overrun_cleared", bus.overrun, 0);
      sb.delete();
      prev = done_cnt;
      repeat (5) tick();
      check("t6_no_done", done_cnt, prev);

      // 7: result_valid already high when reset releases -> captured
      bus.result_matrix = ramp_matrix();
      bus.matrix_size   = 3'd2;
      enqueue_ramp(2);
      bus.result_valid  = 1'b1;
      tick();
      rst = 1'b0;
      wait_done(prev + 1, 20, "t7_done", 1'b0, used);
      bus.result_valid = 1'b0;
      tick();
      check("t7_sb_empty", sb.size(), 0);
      check("t7_no_overrun", bus.overrun, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
